// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry and FSM encoding.
package regfile_mp_pkg;

    localparam int REG_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/execute (master) and the multi-port register file (slave).
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);

    logic                       ready;

    logic [NUM_WR-1:0]          wr_en;
    logic [NUM_WR*ADDR_W-1:0]   wr_addr;
    logic [NUM_WR*DATA_W-1:0]   wr_data;

    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_busy;

    logic                       alloc_en;
    logic [ADDR_W-1:0]          alloc_addr;

    modport master (
        input  ready, rd_data, rd_busy,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, alloc_en, alloc_addr
    );

    modport slave (
        output ready, rd_data, rd_busy,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, alloc_en, alloc_addr
    );

endinterface

// File: rtl/regfile_mp_rd_port.sv
// One combinational read port: priority write bypass, r0 hardwiring and busy masking.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int NUM_WR = 2,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                     run,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        rd_word,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [DEPTH-1:0]         busy,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_busy
);

    logic              hit;
    logic [DATA_W-1:0] byp_data;

    // Later ports overwrite earlier matches, so the highest-index writer is forwarded.
    always_comb begin
        hit      = 1'b0;
        byp_data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == rd_addr)) begin
                hit      = 1'b1;
                byp_data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (run && rd_en && (rd_addr != '0)) begin
            if (hit) begin
                rd_data = byp_data;
            end else begin
                rd_data = rd_word;
                rd_busy = busy[rd_addr];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and a post-reset clear sweep.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    word_t             regs_q [DEPTH];
    word_t             regs_d [DEPTH];
    logic              run;

    assign bus.ready = (state_q == RUN);
    assign run       = (state_q == RUN) && !rst;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        regs_d    = regs_q;
        busy_d    = busy_q;
        unique case (state_q)
            CLEAR: begin
                regs_d[clr_idx_q] = '0;
                clr_idx_d         = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (bus.wr_en[i] && (bus.wr_addr[i*ADDR_W +: ADDR_W] != '0)) begin
                        regs_d[bus.wr_addr[i*ADDR_W +: ADDR_W]] = bus.wr_data[i*DATA_W +: DATA_W];
                        busy_d[bus.wr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
                    end
                end
                // Allocation comes after the write clears: a new producer supersedes the old one.
                if (bus.alloc_en && (bus.alloc_addr != '0)) begin
                    busy_d[bus.alloc_addr] = 1'b1;
                end
            end
            default: ;
        endcase
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // The array itself has no reset; the clear sweep zeroes it after rst drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= regs_d;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] port_data;
        logic              port_busy;

        assign addr = bus.rd_addr[j*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR),
            .DEPTH  (DEPTH)
        ) u_rd_port (
            .run     (run),
            .rd_en   (bus.rd_en[j]),
            .rd_addr (addr),
            .rd_word (regs_q[addr]),
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .busy    (busy_q),
            .rd_data (port_data),
            .rd_busy (port_busy)
        );

        assign bus.rd_data[j*DATA_W +: DATA_W] = port_data;
        assign bus.rd_busy[j]                  = port_busy;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the back end, the successor to the two-read/one-write file. It provides `NUM_RD` combinational read ports and `NUM_WR` synchronous write ports with same-cycle write-to-read bypass. A per-register busy scoreboard lets decode stall on pending producers. A post-reset clear sequencer zeroes the array one entry per cycle, so no register reads X after reset.

## Interface
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: address width; `DEPTH` = 2**`ADDR_W`.
- `NUM_RD`, default 2: read ports.
- `NUM_WR`, default 2: write ports; a higher index has priority.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ready`  out  1  high once the clear sweep is done; reset value 0.
- `wr_en`  in  `NUM_WR`  per-port write enable.
- `wr_addr`  in  `NUM_WR`*`ADDR_W`  flattened write addresses; port i is at bits [i*`ADDR_W` +: `ADDR_W`].
- `wr_data`  in  `NUM_WR`*`DATA_W`  flattened write data.
- `rd_en`  in  `NUM_RD`  per-port read enable.
- `rd_addr`  in  `NUM_RD`*`ADDR_W`  flattened read addresses.
- `rd_data`  out  `NUM_RD`*`DATA_W`  read data; 0 while in reset or while `ready`=0.
- `rd_busy`  out  `NUM_RD`  busy bit of the addressed register; 0 while `ready`=0.
- `alloc_en`  in  1  mark a register busy (decode has issued a producer).
- `alloc_addr`  in  `ADDR_W`  register to mark busy.

## Operation
- The FSM has two states, `CLEAR` and `RUN`. `rst`=1 forces `CLEAR` with `clr_idx`=0 and `busy`=0.
- **CLEAR:**
  - Each cycle with `rst`=0 writes 0 to `regs[clr_idx]` and increments `clr_idx`.
  - When `clr_idx`=`DEPTH`-1, the state moves to `RUN`.
  - `wr_en` and `alloc_en` are ignored. `rd_data` and `rd_busy` output 0.
- **RUN, write:** for each port i with `wr_en[i]`=1 and `wr_addr[i]`≠0, `regs[wr_addr[i]]` ← `wr_data[i]`.
  - If several ports target the same address, the highest index wins.
  - Address 0 is never written.
- **RUN, read:** port j outputs 0 if `rd_en[j]`=0 or `rd_addr[j]`=0.
  - Otherwise, if any port i has `wr_en[i]` and `wr_addr[i]`=`rd_addr[j]`, the port outputs the matching `wr_data` with the highest i (bypass).
  - Otherwise it outputs `regs[rd_addr[j]]`.
- **Scoreboard (RUN only):** `busy[a]` is cleared by any write to a. It is set by `alloc_en` with `alloc_addr`=a≠0.
  - If alloc and write hit the same address in one cycle, set wins (a new producer supersedes).
  - `busy[0]` is constant 0.
  - `rd_busy[j]` = `busy[rd_addr[j]]` & `rd_en[j]`, masked to 0 when a same-cycle write to that address is being bypassed.
- **Reset mid-operation:** `rst` at any edge aborts state and restarts the sweep from entry 0. Pending busy bits are discarded.

## Timing
- Read path is combinational: zero latency; bypass is visible in the same cycle as `wr_en`.
- A write lands at the rising edge. Without bypass, the written value is visible from the next cycle.
- `busy` updates at the edge after `alloc_en` or the write.
- `ready` rises exactly `DEPTH` rising edges after the first edge that samples `rst`=0. Example: `DEPTH`=32 gives 32 cycles.
- Reset values: `ready`=0, `rd_data`=0, `rd_busy`=0, `busy`=0, `clr_idx`=0.

## Structure
- The shared define/package holds:
  - default `DATA_W` and `ADDR_W`, consistent with the existing `RegWidth`/`RegAddrWidth` defines;
  - the FSM state encoding (`CLEAR`=1'b0, `RUN`=1'b1).
- One sub-module, `regfile_rd_port`, instantiated `NUM_RD` times. It takes the array word, all write ports, and `busy`, and produces `rd_data[j]` and `rd_busy[j]` using the priority bypass mux.
- Top level holds the array, the write-priority logic, the scoreboard, and the clear FSM/counter.

## Test plan
- **Reset sweep:** preload X, pulse `rst` for 1 cycle.
  - `ready`=0 for 32 cycles, then 1.
  - Every address then reads 0 and `rd_busy`=0.
- **Write then read, and bypass:**
  - Write 0xDEADBEEF to r5 on port 0; r5 reads it the next cycle.
  - Same-cycle `rd_addr`=5 with `wr_en` and data 0x1234 returns 0x1234 immediately.
- **Write conflict:** ports 0 and 1 write r7 with 0xAAAA and 0xBBBB in one cycle.
  - Same-cycle read returns 0xBBBB.
  - Next cycle r7 = 0xBBBB.
- **r0:** write 0xFFFF to r0, and `alloc_en` r0.
  - r0 reads 0 and `rd_busy`=0.
- **Scoreboard:** alloc r3, so `rd_busy`(r3)=1 next cycle.
  - Write r3 plus alloc r3 in the same cycle: r3 stays busy.
  - A later write clears it.
  - Same-cycle bypass masks `rd_busy` to 0.
- **Reset mid-run:** with r9=0x55 and busy set, assert `rst` for 1 cycle.
  - `ready` drops, writes are ignored during the sweep.
  - After 32 cycles r9 reads 0 and busy is 0.
